// File: rtl/phy_regfile_issue_sched_if.sv
// rtl/phy_regfile_issue_sched_if.sv - decode, writeback and register-read ports of the issue scheduler
interface phy_regfile_issue_sched_if #(
    parameter int PHY_REG_W = 6,
    parameter int TAG_W     = 5,
    parameter int PAYLOAD_W = 64
);
    logic                 in_valid;
    logic                 in_ready;
    logic [PHY_REG_W-1:0] in_src1;
    logic [PHY_REG_W-1:0] in_src2;
    logic                 in_src1_used;
    logic                 in_src2_used;
    logic [PHY_REG_W-1:0] in_dst;
    logic                 in_dst_used;
    logic [TAG_W-1:0]     in_tag;
    logic [PAYLOAD_W-1:0] in_payload;
    logic                 wb_valid;
    logic [PHY_REG_W-1:0] wb_reg;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [PHY_REG_W-1:0] out_src1;
    logic [PHY_REG_W-1:0] out_src2;
    logic [PHY_REG_W-1:0] out_dst;
    logic                 out_dst_used;
    logic [TAG_W-1:0]     out_tag;
    logic [PAYLOAD_W-1:0] out_payload;

    modport master (
        output in_valid, in_src1, in_src2, in_src1_used, in_src2_used,
               in_dst, in_dst_used, in_tag, in_payload,
               wb_valid, wb_reg, flush, out_ready,
        input  in_ready, out_valid, out_src1, out_src2, out_dst,
               out_dst_used, out_tag, out_payload
    );

    modport slave (
        input  in_valid, in_src1, in_src2, in_src1_used, in_src2_used,
               in_dst, in_dst_used, in_tag, in_payload,
               wb_valid, wb_reg, flush, out_ready,
        output in_ready, out_valid, out_src1, out_src2, out_dst,
               out_dst_used, out_tag, out_payload
    );
endinterface

// File: rtl/phy_regfile_issue_sched.sv
// rtl/phy_regfile_issue_sched.sv - age-ordered issue queue with physical register ready scoreboard
module phy_regfile_issue_sched #(
    parameter int DEPTH     = 4,
    parameter int PHY_REG_W = 6,
    parameter int TAG_W     = 5,
    parameter int PAYLOAD_W = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    phy_regfile_issue_sched_if.slave   bus
);
    localparam int NREG  = 1 << PHY_REG_W;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PHY_REG_W-1:0] src1;
        logic [PHY_REG_W-1:0] src2;
        logic [PHY_REG_W-1:0] dst;
        logic                 src1_used;
        logic                 src2_used;
        logic                 dst_used;
        logic [TAG_W-1:0]     tag;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    entry_t             q     [DEPTH];
    entry_t             q_nxt [DEPTH];
    entry_t             new_e;
    entry_t             sel_e;
    entry_t             out_e;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_nxt;
    logic [CNT_W-1:0]   wr_idx;
    logic [NREG-1:0]    sb;
    logic [NREG-1:0]    sb_nxt;
    logic [DEPTH-1:0]   vld;
    logic [DEPTH-1:0]   elig;
    logic [DEPTH-1:0]   sel_oh;
    logic [DEPTH-1:0]   shift_mask;
    logic               any_elig;
    logic               dispatch;
    logic               issue;

    // Entries are contiguous from index 0, so validity follows from count alone.
    always_comb begin
        vld  = '0;
        elig = '0;
        for (int i = 0; i < DEPTH; i++) begin
            vld[i]  = CNT_W'(i) < count;
            elig[i] = vld[i]
                      && (!q[i].src1_used || sb[q[i].src1])
                      && (!q[i].src2_used || sb[q[i].src2]);
        end
    end

    // shift_mask marks the selected entry and everything younger than it.
    always_comb begin
        any_elig   = 1'b0;
        sel_oh     = '0;
        shift_mask = '0;
        sel_e      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sel_oh[i] = elig[i] && !any_elig;
            if (sel_oh[i]) sel_e = q[i];
            any_elig      = any_elig | elig[i];
            shift_mask[i] = any_elig;
        end
    end

    assign bus.in_ready  = !reset && (count < CNT_W'(DEPTH));
    assign bus.out_valid = !reset && any_elig;
    assign out_e         = bus.out_valid ? sel_e : '0;

    assign bus.out_src1     = out_e.src1;
    assign bus.out_src2     = out_e.src2;
    assign bus.out_dst      = out_e.dst;
    assign bus.out_dst_used = out_e.dst_used;
    assign bus.out_tag      = out_e.tag;
    assign bus.out_payload  = out_e.payload;

    assign dispatch = bus.in_valid && bus.in_ready;
    assign issue    = bus.out_valid && bus.out_ready;

    always_comb begin
        new_e.src1      = bus.in_src1;
        new_e.src2      = bus.in_src2;
        new_e.dst       = bus.in_dst;
        new_e.src1_used = bus.in_src1_used;
        new_e.src2_used = bus.in_src2_used;
        new_e.dst_used  = bus.in_dst_used;
        new_e.tag       = bus.in_tag;
        new_e.payload   = bus.in_payload;
    end

    // Compact first, then append the new entry behind the survivors.
    always_comb begin
        q_nxt  = q;
        wr_idx = count - CNT_W'(issue);
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (issue && shift_mask[i]) q_nxt[i] = q[i + 1];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (dispatch && !bus.flush && wr_idx == CNT_W'(i)) q_nxt[i] = new_e;
        end
        if (bus.flush) count_nxt = '0;
        else           count_nxt = count + CNT_W'(dispatch) - CNT_W'(issue);
    end

    // Sets are applied before the allocation clear so the clear wins on a collision.
    always_comb begin
        sb_nxt = sb;
        if (bus.wb_valid) sb_nxt[bus.wb_reg] = 1'b1;
        if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (vld[i] && q[i].dst_used && !(issue && sel_oh[i])) sb_nxt[q[i].dst] = 1'b1;
            end
        end
        if (dispatch && !bus.flush && bus.in_dst_used && bus.in_dst != '0)
            sb_nxt[bus.in_dst] = 1'b0;
        sb_nxt[0] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            sb    <= '1;
        end else begin
            count <= count_nxt;
            sb    <= sb_nxt;
        end
    end

    always_ff @(posedge clk) begin
        q <= q_nxt;
    end
endmodule

// File: tb/tb_phy_regfile_issue_sched.sv
// tb/tb_phy_regfile_issue_sched.sv - directed self-checking bench for phy_regfile_issue_sched
module tb_phy_regfile_issue_sched;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    phy_regfile_issue_sched_if bus ();

    phy_regfile_issue_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset)
            assert (!(bus.in_valid && bus.in_ready && bus.in_dst_used && bus.in_dst != 0
                      && bus.wb_valid && bus.wb_reg == bus.in_dst && !bus.flush))
            else $error("illegal allocation/writeback collision on reg %0d", bus.in_dst);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pay(input logic [4:0] t);
        return {32'hC0DE_0000, 27'd0, t};
    endfunction

    task automatic drive(input logic [5:0] s1, input logic s1u, input logic [5:0] s2,
                         input logic s2u, input logic [5:0] d, input logic du, input logic [4:0] t);
        bus.in_valid     = 1'b1;
        bus.in_src1      = s1;
        bus.in_src1_used = s1u;
        bus.in_src2      = s2;
        bus.in_src2_used = s2u;
        bus.in_dst       = d;
        bus.in_dst_used  = du;
        bus.in_tag       = t;
        bus.in_payload   = pay(t);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        #1;
    endtask

    task automatic wb(input logic [5:0] r);
        bus.wb_valid = 1'b1;
        bus.wb_reg   = r;
        tick();
        bus.wb_valid = 1'b0;
        #1;
    endtask

    initial begin
        bus.in_valid = 0; bus.in_src1 = 0; bus.in_src2 = 0; bus.in_src1_used = 0;
        bus.in_src2_used = 0; bus.in_dst = 0; bus.in_dst_used = 0; bus.in_tag = 0;
        bus.in_payload = 0; bus.wb_valid = 0; bus.wb_reg = 0; bus.flush = 0; bus.out_ready = 0;

        tick();
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_payload", bus.out_payload, 0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);
        check("post_rst_sb", dut.sb, ALL_ONES);
        check("post_rst_count", dut.count, 0);

        // basic issue
        bus.out_ready = 1'b1;
        drive(6'd3, 1, 6'd4, 1, 6'd10, 1, 5'd7);
        check("empty_no_passthru", bus.out_valid, 0);
        tick();
        idle();
        check("basic_out_valid", bus.out_valid, 1);
        check("basic_out_tag", bus.out_tag, 7);
        check("basic_out_src1", bus.out_src1, 3);
        check("basic_out_src2", bus.out_src2, 4);
        check("basic_out_dst", bus.out_dst, 10);
        check("basic_payload", bus.out_payload, pay(5'd7));
        check("basic_sb10_clear", dut.sb[10], 0);
        tick();
        check("basic_drained", bus.out_valid, 0);
        check("basic_sb10_still_clear", dut.sb[10], 0);
        wb(6'd10);
        check("basic_sb10_set", dut.sb[10], 1);

        // dependency wakeup
        drive(6'd0, 0, 6'd0, 0, 6'd10, 1, 5'd1);
        tick();
        drive(6'd10, 1, 6'd0, 0, 6'd11, 1, 5'd2);
        check("dep_a_tag", bus.out_tag, 1);
        tick();
        idle();
        check("dep_b_wait1", bus.out_valid, 0);
        tick();
        check("dep_b_wait2", bus.out_valid, 0);
        bus.wb_valid = 1'b1;
        bus.wb_reg   = 6'd10;
        #1;
        check("dep_no_bypass", bus.out_valid, 0);
        tick();
        bus.wb_valid = 1'b0;
        #1;
        check("dep_b_valid", bus.out_valid, 1);
        check("dep_b_tag", bus.out_tag, 2);
        check("dep_b_src1", bus.out_src1, 10);
        tick();
        check("dep_count", dut.count, 0);
        wb(6'd11);

        // out-of-order selection
        drive(6'd0, 0, 6'd0, 0, 6'd12, 1, 5'd9);
        tick();
        idle();
        tick();
        bus.out_ready = 1'b0;
        drive(6'd12, 1, 6'd0, 0, 6'd0, 0, 5'd1);
        tick();
        drive(6'd0, 0, 6'd0, 0, 6'd0, 0, 5'd2);
        tick();
        drive(6'd0, 0, 6'd0, 0, 6'd0, 0, 5'd3);
        tick();
        idle();
        check("ooo_count3", dut.count, 3);
        check("ooo_first_tag", bus.out_tag, 2);
        tick();
        check("ooo_hold_tag", bus.out_tag, 2);
        bus.out_ready = 1'b1;
        tick();
        check("ooo_second_tag", bus.out_tag, 3);
        tick();
        check("ooo_blocked", bus.out_valid, 0);
        check("ooo_count1", dut.count, 1);
        check("ooo_head_tag", dut.q[0].tag, 1);
        wb(6'd12);
        check("ooo_wake_valid", bus.out_valid, 1);
        check("ooo_wake_tag", bus.out_tag, 1);
        tick();
        check("ooo_empty", dut.count, 0);

        // full and simultaneous dispatch/issue
        bus.out_ready = 1'b0;
        for (int t = 4; t < 8; t++) begin
            drive(6'd0, 0, 6'd0, 0, 6'd0, 0, 5'(t));
            tick();
        end
        drive(6'd0, 0, 6'd0, 0, 6'd0, 0, 5'd8);
        check("full_count", dut.count, 4);
        check("full_in_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        #1;
        check("full_issue_in_ready", bus.in_ready, 0);
        tick();
        check("after_full_count", dut.count, 3);
        check("after_full_in_ready", bus.in_ready, 1);
        tick();
        check("simul_count", dut.count, 3);
        check("simul_youngest", dut.q[2].tag, 8);
        check("simul_oldest", dut.q[0].tag, 6);
        check("simul_out_tag", bus.out_tag, 6);
        idle();
        tick(); tick(); tick();
        check("full_drained", dut.count, 0);

        // flush
        bus.out_ready = 1'b0;
        drive(6'd0, 0, 6'd0, 0, 6'd20, 1, 5'd10);
        tick();
        drive(6'd0, 0, 6'd0, 0, 6'd21, 1, 5'd11);
        tick();
        drive(6'd0, 0, 6'd0, 0, 6'd0, 0, 5'd12);
        tick();
        check("pre_flush_sb20", dut.sb[20], 0);
        check("pre_flush_sb21", dut.sb[21], 0);
        bus.flush = 1'b1;
        drive(6'd0, 0, 6'd0, 0, 6'd22, 1, 5'd13);
        tick();
        bus.flush = 1'b0;
        idle();
        check("flush_count", dut.count, 0);
        check("flush_out_valid", bus.out_valid, 0);
        check("flush_sb_all", dut.sb, ALL_ONES);

        // reset mid-operation
        drive(6'd0, 0, 6'd0, 0, 6'd30, 1, 5'd14);
        tick();
        drive(6'd0, 0, 6'd0, 0, 6'd0, 0, 5'd15);
        tick();
        check("mid_count", dut.count, 2);
        reset = 1'b1;
        drive(6'd0, 0, 6'd0, 0, 6'd31, 1, 5'd16);
        check("mid_rst_in_ready", bus.in_ready, 0);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_out_tag", bus.out_tag, 0);
        tick();
        idle();
        check("mid_rst_count", dut.count, 0);
        check("mid_rst_sb", dut.sb, ALL_ONES);
        reset = 1'b0;
        #1;
        check("mid_rst_release_ready", bus.in_ready, 1);
        check("mid_rst_release_valid", bus.out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
